// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage register with valid/ready handshake, flush and an optional
// two-entry skid buffer so in_ready can come straight from a flop.
module if_id_pipe_stage #(
    parameter int                 INSTR_W     = 16,
    parameter int                 PC_W        = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = 16'h0800,
    parameter bit                 SKID        = 1'b1,
    parameter int                 STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [PC_W-1:0]        out_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    logic               held_valid;
    logic [INSTR_W-1:0] held_instr;
    logic [PC_W-1:0]    held_pc;
    logic               accept;
    logic               consume;

    assign accept  = in_valid && in_ready;
    assign consume = held_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            state_t             state_q;
            state_t             state_d;
            logic               in_ready_q;
            logic [INSTR_W-1:0] main_instr_q;
            logic [PC_W-1:0]    main_pc_q;
            logic [INSTR_W-1:0] skid_instr_q;
            logic [PC_W-1:0]    skid_pc_q;

            // Occupancy tracking; flush overrides everything and drops to empty.
            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (accept) state_d = ST_ONE;
                        ST_ONE: begin
                            if (accept && !consume)
                                state_d = ST_FULL;
                            else if (!accept && consume)
                                state_d = ST_EMPTY;
                        end
                        ST_FULL:  if (consume) state_d = ST_ONE;
                        default:  state_d = ST_EMPTY;
                    endcase
                end
            end

            // in_ready is looked ahead from the next state so it never depends on out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_instr_q <= NOP_INSTR;
                    main_pc_q    <= '0;
                    skid_instr_q <= NOP_INSTR;
                    skid_pc_q    <= '0;
                end else if (!flush) begin
                    if (accept && (state_q == ST_EMPTY || consume)) begin
                        main_instr_q <= in_instr;
                        main_pc_q    <= in_pc;
                    end else if (state_q == ST_FULL && consume) begin
                        main_instr_q <= skid_instr_q;
                        main_pc_q    <= skid_pc_q;
                    end
                    if (accept && state_q == ST_ONE && !consume) begin
                        skid_instr_q <= in_instr;
                        skid_pc_q    <= in_pc;
                    end
                end
            end

            assign in_ready   = in_ready_q;
            assign held_valid = (state_q != ST_EMPTY);
            assign held_instr = main_instr_q;
            assign held_pc    = main_pc_q;
        end else begin : g_single
            logic               valid_q;
            logic [INSTR_W-1:0] instr_q;
            logic [PC_W-1:0]    pc_q;

            assign in_ready = !valid_q || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                    pc_q    <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    instr_q <= in_instr;
                    pc_q    <= in_pc;
                end else if (consume) begin
                    valid_q <= 1'b0;
                end
            end

            assign held_valid = valid_q;
            assign held_instr = instr_q;
            assign held_pc    = pc_q;
        end
    endgenerate

    assign out_valid = held_valid;
    assign out_instr = held_valid ? held_instr : NOP_INSTR;
    assign out_pc    = held_valid ? held_pc : '0;

    // Saturating count of back-pressured cycles; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (held_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Bench for if_id_pipe_stage: a skid build and a single-register build run side by side,
// each checked against its own queue of expected beats.
module tb_if_id_pipe_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid_s, in_ready_s, flush_s, out_valid_s, out_ready_s;
    logic [15:0] in_instr_s, in_pc_s, out_instr_s, out_pc_s;
    logic [7:0]  stall_cnt_s;

    logic        in_valid_r, in_ready_r, flush_r, out_valid_r, out_ready_r;
    logic [15:0] in_instr_r, in_pc_r, out_instr_r, out_pc_r;
    logic [7:0]  stall_cnt_r;

    beat_t       q_s[$];
    beat_t       q_r[$];
    logic [7:0]  exp_stall_s, exp_stall_r;
    bit          acc_s;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    if_id_pipe_stage #(.SKID(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_instr(in_instr_s), .in_pc(in_pc_s),
        .flush(flush_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_instr(out_instr_s), .out_pc(out_pc_s),
        .stall_cnt(stall_cnt_s)
    );

    if_id_pipe_stage #(.SKID(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_r), .in_ready(in_ready_r), .in_instr(in_instr_r), .in_pc(in_pc_r),
        .flush(flush_r),
        .out_valid(out_valid_r), .out_ready(out_ready_r), .out_instr(out_instr_r), .out_pc(out_pc_r),
        .stall_cnt(stall_cnt_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset();
        check("rst_s_valid", {31'd0, out_valid_s}, 32'd0);
        check("rst_s_instr", {16'd0, out_instr_s}, 32'h0800);
        check("rst_s_pc", {16'd0, out_pc_s}, 32'd0);
        check("rst_s_stall", {24'd0, stall_cnt_s}, 32'd0);
        check("rst_r_valid", {31'd0, out_valid_r}, 32'd0);
        check("rst_r_instr", {16'd0, out_instr_r}, 32'h0800);
        check("rst_r_pc", {16'd0, out_pc_r}, 32'd0);
        check("rst_r_stall", {24'd0, stall_cnt_r}, 32'd0);
        q_s.delete();
        q_r.delete();
        exp_stall_s = 8'd0;
        exp_stall_r = 8'd0;
    endtask

    // One clock: compare both DUTs to their models mid-cycle, advance the models, cross the edge.
    task automatic step();
        bit ev_s, er_s, ev_r, er_r;
        @(negedge clk);
        ev_s = (q_s.size() > 0);
        er_s = (q_s.size() < 2);
        ev_r = (q_r.size() > 0);
        er_r = !ev_r || out_ready_r;
        check("s_out_valid", {31'd0, out_valid_s}, {31'd0, ev_s});
        check("s_in_ready", {31'd0, in_ready_s}, {31'd0, er_s});
        check("s_out_instr", {16'd0, out_instr_s}, ev_s ? {16'd0, q_s[0].instr} : 32'h0800);
        check("s_out_pc", {16'd0, out_pc_s}, ev_s ? {16'd0, q_s[0].pc} : 32'd0);
        check("s_stall_cnt", {24'd0, stall_cnt_s}, {24'd0, exp_stall_s});
        check("r_out_valid", {31'd0, out_valid_r}, {31'd0, ev_r});
        check("r_in_ready", {31'd0, in_ready_r}, {31'd0, er_r});
        check("r_out_instr", {16'd0, out_instr_r}, ev_r ? {16'd0, q_r[0].instr} : 32'h0800);
        check("r_out_pc", {16'd0, out_pc_r}, ev_r ? {16'd0, q_r[0].pc} : 32'd0);
        check("r_stall_cnt", {24'd0, stall_cnt_r}, {24'd0, exp_stall_r});

        if (ev_s && !out_ready_s && exp_stall_s != 8'hFF) exp_stall_s++;
        if (ev_r && !out_ready_r && exp_stall_r != 8'hFF) exp_stall_r++;
        if (ev_s && out_ready_s) void'(q_s.pop_front());
        if (ev_r && out_ready_r) void'(q_r.pop_front());
        acc_s = in_valid_s && er_s && !flush_s;
        if (flush_s) q_s.delete();
        else if (acc_s) q_s.push_back({in_instr_s, in_pc_s});
        if (flush_r) q_r.delete();
        else if (in_valid_r && er_r) q_r.push_back({in_instr_r, in_pc_r});
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                                 input logic ordy, input logic fl);
        in_valid_s  = v;
        in_instr_s  = instr;
        in_pc_s     = pc;
        out_ready_s = ordy;
        flush_s     = fl;
    endtask

    initial begin
        int idx;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        in_valid_r = 1'b0; in_instr_r = '0; in_pc_r = '0; out_ready_r = 1'b1; flush_r = 1'b0;
        exp_stall_s = 8'd0;
        exp_stall_r = 8'd0;
        #12;
        checkReset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Back-to-back streaming with no back-pressure.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'hA000 + 16'(i), 16'(2 * i), 1'b1, 1'b0);
            step();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        step();

        // Reset while beats are held.
        applyStimulus(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0);
        in_valid_r = 1'b1; in_instr_r = 16'h2222; in_pc_r = 16'h0020; out_ready_r = 1'b0;
        step();
        applyStimulus(1'b1, 16'h1112, 16'h0012, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        checkReset();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        in_valid_r = 1'b0; out_ready_r = 1'b1;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Long stall with fetch pushing: skid absorbs two beats, counter saturates.
        idx = 0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b1, 16'hB000 + 16'(idx), 16'(2 * idx), 1'b0, 1'b0);
            step();
            if (acc_s) idx++;
        end
        check("stall_accepted", idx, 32'd2);
        check("stall_sat", {24'd0, stall_cnt_s}, 32'hFF);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (3) step();

        // Flush while full with a beat offered in the same cycle.
        applyStimulus(1'b1, 16'hC001, 16'h0040, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 16'hC002, 16'h0042, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 16'hDEAD, 16'h0044, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("flush_empty", {31'd0, out_valid_s}, 32'd0);
        check("flush_ready", {31'd0, in_ready_s}, 32'd1);
        step();
        step();

        // Flush coinciding with consume.
        applyStimulus(1'b1, 16'hE001, 16'h0050, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("flush_consume_q", q_s.size(), 32'd0);
        step();

        // Randomised traffic on both builds.
        for (int c = 0; c < 10000; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
            in_valid_r  = $urandom_range(0, 3) != 0;
            in_instr_r  = 16'($urandom);
            in_pc_r     = 16'($urandom);
            out_ready_r = $urandom_range(0, 2) != 0;
            flush_r     = $urandom_range(0, 63) == 0;
            step();
        end

        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        in_valid_r = 1'b0; out_ready_r = 1'b1; flush_r = 1'b0;
        repeat (4) step();
        check("drain_s", q_s.size(), 32'd0);
        check("drain_r", q_r.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
